// File: rtl/mips_core_pkg.sv
// Shared core types: memory access kind and the store-buffer entry record.
// Width macros normally arrive from the core header; guarded defaults keep this file standalone.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_access_type;

   typedef struct packed {
      logic [`ADDR_WIDTH-1:0] addr;
      logic [`DATA_WIDTH-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// EX-stage request, forwarding result and d-cache drain channel of the store buffer.
// Drain handshake: a write retires on a cycle where o_dc_valid and i_dc_ready are both high;
// o_dc_valid, o_dc_addr and o_dc_data stay stable until that cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface store_buffer_if;
   import mips_core_pkg::*;

   logic                    i_valid;
   mem_access_type          i_mem_action;
   logic [`ADDR_WIDTH-1:0]  i_addr;
   logic [`DATA_WIDTH-1:0]  i_data;
   logic                    o_stall;
   logic                    o_fwd_hit;
   logic [`DATA_WIDTH-1:0]  o_fwd_data;
   logic                    o_dc_valid;
   logic [`ADDR_WIDTH-1:0]  o_dc_addr;
   logic [`DATA_WIDTH-1:0]  o_dc_data;
   logic                    i_dc_ready;
   logic                    o_empty;

   modport master (
      output i_valid, i_mem_action, i_addr, i_data, i_dc_ready,
      input  o_stall, o_fwd_hit, o_fwd_data, o_dc_valid, o_dc_addr, o_dc_data, o_empty
   );

   modport slave (
      input  i_valid, i_mem_action, i_addr, i_data, i_dc_ready,
      output o_stall, o_fwd_hit, o_fwd_data, o_dc_valid, o_dc_addr, o_dc_data, o_empty
   );
endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match search over the occupied store-buffer entries for load forwarding.
// Walks from head toward tail so a later (younger) match overrides an older one.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_buffer_match
   import mips_core_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  sb_entry_t [DEPTH-1:0]   entries,
   input  logic [DEPTH-1:0]        occupied,
   input  logic [PW-1:0]           head,
   input  logic [PW:0]             count,
   input  logic                    enable,
   input  logic [`ADDR_WIDTH-1:0]  addr,
   output logic                    hit,
   output logic [`DATA_WIDTH-1:0]  data
);

   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (enable && ((PW+1)'(i) < count) && occupied[head + PW'(i)] &&
             (entries[head + PW'(i)].addr == addr)) begin
            hit  = 1'b1;
            data = entries[head + PW'(i)].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between EX and the d-cache: queues stores, drains them in
// program order and forwards the youngest matching store to loads in the same cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_buffer
   import mips_core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   store_buffer_if.slave          sb,
   output logic [$clog2(DEPTH):0] dbg_count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   sb_entry_t [DEPTH-1:0]  entries;
   logic [DEPTH-1:0]       occupied;
   logic [PW-1:0]          head;
   logic [PW-1:0]          tail;
   logic [PW:0]            count;
   logic                   is_write;
   logic                   is_read;
   logic                   pop;
   logic                   push;
   logic                   fwd_hit;
   logic [`DATA_WIDTH-1:0] fwd_data;

   assign is_write = sb.i_valid && (sb.i_mem_action == WRITE);
   assign is_read  = sb.i_valid && (sb.i_mem_action == READ);
   assign pop      = (count != '0) && sb.i_dc_ready;
   // A full buffer still takes a store when the head retires in the same cycle.
   assign push     = is_write && ((count != FULL) || pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         occupied <= '0;
      end else begin
         if (pop) begin
            head           <= head + PW'(1);
            occupied[head] <= 1'b0;
         end
         // When full with push and pop together, tail equals head and the set must win.
         if (push) begin
            tail           <= tail + PW'(1);
            occupied[tail] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payloads carry no reset; occupancy alone decides whether they are live.
   always_ff @(posedge clk) begin
      if (push) begin
         entries[tail] <= '{addr: sb.i_addr, data: sb.i_data};
      end
   end

   store_buffer_match #(.DEPTH(DEPTH)) u_match (
      .entries  (entries),
      .occupied (occupied),
      .head     (head),
      .count    (count),
      .enable   (is_read),
      .addr     (sb.i_addr),
      .hit      (fwd_hit),
      .data     (fwd_data)
   );

   assign sb.o_stall    = is_write && (count == FULL) && !pop;
   assign sb.o_fwd_hit  = fwd_hit;
   assign sb.o_fwd_data = fwd_data;
   assign sb.o_dc_valid = (count != '0);
   assign sb.o_dc_addr  = entries[head].addr;
   assign sb.o_dc_data  = entries[head].data;
   assign sb.o_empty    = (count == '0);
   assign dbg_count     = count;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the buffer.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_store_buffer;
   import mips_core_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `DATA_WIDTH;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [$clog2(DEPTH):0]  dbg_count;

   store_buffer_if sb ();

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .sb        (sb),
      .dbg_count (dbg_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW+DW-1:0] exp_q[$];

   typedef struct {
      bit             v;
      mem_access_type act;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  data;
      bit             rdy;
      int             exp_count;
      bit             exp_dcv;
      logic [AW-1:0]  exp_dc_addr;
      logic [DW-1:0]  exp_dc_data;
      bit             exp_stall;
      bit             exp_hit;
      logic [DW-1:0]  exp_fwd;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(bit v, mem_access_type act, logic [AW-1:0] a, logic [DW-1:0] d,
                               bit rdy, int cnt, bit dcv, logic [AW-1:0] da, logic [DW-1:0] dd,
                               bit st, bit h, logic [DW-1:0] f);
      vec_t r;
      r.v = v; r.act = act; r.addr = a; r.data = d; r.rdy = rdy;
      r.exp_count = cnt; r.exp_dcv = dcv; r.exp_dc_addr = da; r.exp_dc_data = dd;
      r.exp_stall = st; r.exp_hit = h; r.exp_fwd = f;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit v, input mem_access_type act, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rdy);
      sb.i_valid      = v;
      sb.i_mem_action = act;
      sb.i_addr       = a;
      sb.i_data       = d;
      sb.i_dc_ready   = rdy;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      drive(1'b0, READ, '0, '0, 1'b0);
      rst = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // One cycle against the queue model: checks offered outputs, then commits pop/push.
   task automatic model_cycle(input bit v, input mem_access_type act, input logic [AW-1:0] a,
                              input logic [DW-1:0] d, input bit rdy, output bit pushed);
      int            n;
      bit            pop;
      bit            wr;
      bit            stall;
      bit            hit;
      logic [DW-1:0] fwd;
      drive(v, act, a, d, rdy);
      @(negedge clk);
      n     = exp_q.size();
      pop   = (n != 0) && rdy;
      wr    = v && (act == WRITE);
      stall = wr && (n == DEPTH) && !pop;
      hit   = 1'b0;
      fwd   = '0;
      if (v && act == READ) begin
         for (int i = n - 1; i >= 0; i--) begin
            if (exp_q[i][AW+DW-1:DW] == a) begin
               hit = 1'b1;
               fwd = exp_q[i][DW-1:0];
               break;
            end
         end
      end
      check("rnd_count", 64'(dbg_count), 64'(n));
      check("rnd_dc_valid", 64'(sb.o_dc_valid), 64'(n != 0));
      check("rnd_empty", 64'(sb.o_empty), 64'(n == 0));
      check("rnd_stall", 64'(sb.o_stall), 64'(stall));
      check("rnd_fwd_hit", 64'(sb.o_fwd_hit), 64'(hit));
      check("rnd_fwd_data", 64'(sb.o_fwd_data), 64'(fwd));
      if (n != 0) check("drain_order", 64'({sb.o_dc_addr, sb.o_dc_data}), 64'(exp_q[0]));
      if (pop) void'(exp_q.pop_front());
      pushed = wr && !stall;
      if (pushed) exp_q.push_back({a, d});
      next_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      bit            pushed;
      int            stores;
      int            cycles;
      bit            v;
      mem_access_type act;
      logic [AW-1:0] a;
      int            r;

      // Reset state, with live requests present on the bus.
      rst = 1'b1;
      drive(1'b1, READ, 32'h100, 32'h0, 1'b1);
      #1;
      check("rst_dc_valid", 64'(sb.o_dc_valid), 64'd0);
      check("rst_empty", 64'(sb.o_empty), 64'd1);
      check("rst_fwd_hit", 64'(sb.o_fwd_hit), 64'd0);
      check("rst_fwd_data", 64'(sb.o_fwd_data), 64'd0);
      drive(1'b1, WRITE, 32'h100, 32'h5, 1'b0);
      #1;
      check("rst_stall", 64'(sb.o_stall), 64'd0);
      check("rst_count", 64'(dbg_count), 64'd0);
      do_reset();

      // Directed table: expectations are the values seen before the clock edge of that row.
      vecs[0]  = mk(1, WRITE, 32'h100, 32'hAAAA, 0, 0, 0, 32'h0,   32'h0,    0, 0, 32'h0);
      vecs[1]  = mk(1, WRITE, 32'h0A0, 32'h1,    0, 1, 1, 32'h100, 32'hAAAA, 0, 0, 32'h0);
      vecs[2]  = mk(1, WRITE, 32'h0A0, 32'h2,    0, 2, 1, 32'h100, 32'hAAAA, 0, 0, 32'h0);
      vecs[3]  = mk(1, READ,  32'h0A0, 32'h0,    0, 3, 1, 32'h100, 32'hAAAA, 0, 1, 32'h2);
      vecs[4]  = mk(1, READ,  32'h100, 32'h0,    0, 3, 1, 32'h100, 32'hAAAA, 0, 1, 32'hAAAA);
      vecs[5]  = mk(1, READ,  32'h104, 32'h0,    0, 3, 1, 32'h100, 32'hAAAA, 0, 0, 32'h0);
      vecs[6]  = mk(1, WRITE, 32'h0B0, 32'h3,    0, 3, 1, 32'h100, 32'hAAAA, 0, 0, 32'h0);
      vecs[7]  = mk(1, WRITE, 32'h0C0, 32'h4,    0, 4, 1, 32'h100, 32'hAAAA, 1, 0, 32'h0);
      vecs[8]  = mk(1, WRITE, 32'h0C0, 32'h4,    1, 4, 1, 32'h100, 32'hAAAA, 0, 0, 32'h0);
      vecs[9]  = mk(0, READ,  32'h000, 32'h0,    0, 4, 1, 32'h0A0, 32'h1,    0, 0, 32'h0);
      vecs[10] = mk(1, READ,  32'h0A0, 32'h0,    1, 4, 1, 32'h0A0, 32'h1,    0, 1, 32'h2);
      vecs[11] = mk(0, WRITE, 32'h0B0, 32'h9,    0, 3, 1, 32'h0A0, 32'h2,    0, 0, 32'h0);
      vecs[12] = mk(0, READ,  32'h0B0, 32'h0,    0, 3, 1, 32'h0A0, 32'h2,    0, 0, 32'h0);
      vecs[13] = mk(1, READ,  32'h0B0, 32'h0,    0, 3, 1, 32'h0A0, 32'h2,    0, 1, 32'h3);
      vecs[14] = mk(1, WRITE, 32'h0D0, 32'h5,    0, 3, 1, 32'h0A0, 32'h2,    0, 0, 32'h0);
      vecs[15] = mk(1, WRITE, 32'h0E0, 32'h6,    0, 4, 1, 32'h0A0, 32'h2,    1, 0, 32'h0);
      vecs[16] = mk(1, READ,  32'h0C0, 32'h0,    0, 4, 1, 32'h0A0, 32'h2,    0, 1, 32'h4);

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].v, vecs[i].act, vecs[i].addr, vecs[i].data, vecs[i].rdy);
         @(negedge clk);
         check($sformatf("vec%0d_count", i), 64'(dbg_count), 64'(vecs[i].exp_count));
         check($sformatf("vec%0d_dc_valid", i), 64'(sb.o_dc_valid), 64'(vecs[i].exp_dcv));
         if (vecs[i].exp_dcv) begin
            check($sformatf("vec%0d_dc_addr", i), 64'(sb.o_dc_addr), 64'(vecs[i].exp_dc_addr));
            check($sformatf("vec%0d_dc_data", i), 64'(sb.o_dc_data), 64'(vecs[i].exp_dc_data));
         end
         check($sformatf("vec%0d_stall", i), 64'(sb.o_stall), 64'(vecs[i].exp_stall));
         check($sformatf("vec%0d_fwd_hit", i), 64'(sb.o_fwd_hit), 64'(vecs[i].exp_hit));
         check($sformatf("vec%0d_fwd_data", i), 64'(sb.o_fwd_data), 64'(vecs[i].exp_fwd));
         next_cycle();
      end

      // Load to the head address on the very cycle the head drains.
      do_reset();
      drive(1, WRITE, 32'h10, 32'h11, 0); next_cycle();
      drive(1, WRITE, 32'h20, 32'h22, 0); next_cycle();
      drive(1, WRITE, 32'h30, 32'h33, 0); next_cycle();
      drive(1, READ, 32'h10, 32'h0, 1);
      @(negedge clk);
      check("popfwd_hit", 64'(sb.o_fwd_hit), 64'd1);
      check("popfwd_data", 64'(sb.o_fwd_data), 64'h11);
      check("popfwd_dc_addr", 64'(sb.o_dc_addr), 64'h10);
      next_cycle();
      drive(0, READ, 32'h0, 32'h0, 0);
      @(negedge clk);
      check("popfwd_next_addr", 64'(sb.o_dc_addr), 64'h20);
      check("popfwd_next_count", 64'(dbg_count), 64'd2);
      next_cycle();

      // Asynchronous reset mid-operation, with a drain about to retire.
      do_reset();
      drive(1, WRITE, 32'h40, 32'h44, 0); next_cycle();
      drive(1, WRITE, 32'h50, 32'h55, 0); next_cycle();
      drive(1, WRITE, 32'h60, 32'h66, 0); next_cycle();
      drive(1, READ, 32'h50, 32'h0, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_dc_valid", 64'(sb.o_dc_valid), 64'd0);
      check("arst_empty", 64'(sb.o_empty), 64'd1);
      check("arst_fwd_hit", 64'(sb.o_fwd_hit), 64'd0);
      check("arst_fwd_data", 64'(sb.o_fwd_data), 64'd0);
      check("arst_count", 64'(dbg_count), 64'd0);
      next_cycle();
      rst = 1'b0;
      drive(0, READ, 32'h0, 32'h0, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("arst_no_drain", 64'(sb.o_dc_valid), 64'd0);
         next_cycle();
      end

      // Randomized run: 12 accepted stores mixed with loads and idles, random drain readiness.
      do_reset();
      stores = 0;
      cycles = 0;
      while (stores < 12 && cycles < 400) begin
         r = $urandom_range(0, 3);
         v = (r != 3);
         act = (r <= 1) ? WRITE : READ;
         a = 32'h200 + 32'($urandom_range(0, 3)) * 32'd4;
         model_cycle(v, act, a, 32'($urandom), 1'($urandom_range(0, 1)), pushed);
         if (pushed) stores++;
         cycles++;
      end
      check("rnd_stores_pushed", 64'(stores), 64'd12);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 50) begin
         model_cycle(0, READ, 32'h0, 32'h0, 1, pushed);
         cycles++;
      end
      check("rnd_drained", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
      check("rnd_final_empty", 64'(sb.o_empty), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single core clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_valid, input, 1 bit: the EX-stage memory request is valid this cycle.
REQ-005 The block SHALL have port i_mem_action, input, mips_core_pkg::mem_access_type: READ or WRITE.
REQ-006 The block SHALL have port i_addr, input, `ADDR_WIDTH bits: word address, with the thread-ID MSB already applied upstream.
REQ-007 The block SHALL have port i_data, input, `DATA_WIDTH bits: store data.
REQ-008 The block SHALL have port o_stall, output, 1 bit: store not accepted this cycle; the upstream stage holds.
REQ-009 The block SHALL have port o_fwd_hit, output, 1 bit: the load address matches a buffered store.
REQ-010 The block SHALL have port o_fwd_data, output, `DATA_WIDTH bits: forwarded load data.
REQ-011 The block SHALL have port o_dc_valid, output, 1 bit: a drain write to the d-cache is offered.
REQ-012 The block SHALL have port o_dc_addr, output, `ADDR_WIDTH bits: drain address.
REQ-013 The block SHALL have port o_dc_data, output, `DATA_WIDTH bits: drain data.
REQ-014 The block SHALL have port i_dc_ready, input, 1 bit: the d-cache accepts the drain write this cycle.
REQ-015 The block SHALL have port o_empty, output, 1 bit: no stores are buffered (used for halt/drain).

Function
REQ-016 Storage SHALL be a circular FIFO: head pointer and tail pointer of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count of $clog2(DEPTH)+1 bits.
REQ-017 Pop SHALL occur when o_dc_valid and i_dc_ready are both high; it advances head and frees the head entry.
REQ-018 Push SHALL occur when i_valid is high, i_mem_action is WRITE, and (count < DEPTH or pop is true in the same cycle); it writes {i_addr, i_data} at tail and advances tail.
REQ-019 o_stall SHALL be high exactly when i_valid is high, i_mem_action is WRITE, count equals DEPTH and no pop occurs in that cycle; it is combinational and depends on i_dc_ready.
REQ-020 On simultaneous push and pop, count SHALL be unchanged; with push only, count SHALL increase by 1; with pop only, count SHALL decrease by 1.
REQ-021 o_dc_valid SHALL equal (count != 0); o_dc_addr and o_dc_data SHALL present the head entry and hold stable until pop.
REQ-022 Once raised, o_dc_valid SHALL NOT drop before the pop that retires the head entry.
REQ-023 Forwarding SHALL be combinational: when i_valid is high and i_mem_action is READ, compare i_addr against every occupied entry, including a head entry being popped in the same cycle.
REQ-024 With multiple matches, the youngest entry (nearest tail) SHALL win; o_fwd_hit is high and o_fwd_data carries that entry's data.
REQ-025 o_fwd_hit SHALL be 0 for WRITE requests, when i_valid is low, and when no entry matches; o_fwd_data is then 0.
REQ-026 Stores to an address already buffered SHALL allocate a new entry; there is no coalescing.
REQ-027 Drain order SHALL equal program order.
REQ-028 Load latency for forwarded data SHALL be 0 cycles; push-to-first-offer latency SHALL be 1 cycle.
REQ-029 o_empty SHALL equal (count == 0).

Reset
REQ-030 When rst is asserted, the block SHALL immediately clear head, tail, count and all entry valid bits.
REQ-031 During reset, outputs SHALL be: o_dc_valid=0, o_empty=1, o_fwd_hit=0, o_fwd_data=0, o_stall=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered stores and any in-flight drain; entry data contents need not be cleared.

Structure
REQ-033 mips_core_pkg SHALL gain typedef sb_entry_t as a struct {addr, data}; the existing mem_access_type and the `ADDR_WIDTH/`DATA_WIDTH macros from mips_core.svh SHALL be reused.
REQ-034 The youngest-match search SHALL be a sub-module store_buffer_match, taking occupied entries, head and count, and producing hit and data.

Verification
REQ-035 The bench SHALL, from reset, push WRITE 0x100/0xAAAA with i_dc_ready=0 and check: next cycle o_dc_valid=1, o_dc_addr=0x100, o_dc_data=0xAAAA, count=1.
REQ-036 The bench SHALL push WRITE A/1, then WRITE A/2, then READ A, and check o_fwd_hit=1 and o_fwd_data=2.
REQ-037 The bench SHALL fill 4 entries with i_dc_ready=0 and check that a 5th WRITE gives o_stall=1; with i_dc_ready=1 in the same cycle it SHALL give o_stall=0, count stays 4, and the head advances.
REQ-038 The bench SHALL fill 3 entries, then on the cycle of the head's pop issue READ to the head address, and check o_fwd_hit=1 with the head data.
REQ-039 The bench SHALL assert rst asynchronously with 3 entries buffered and check o_dc_valid=0 and o_empty=1 before the next clock edge, with no further drain writes afterwards.
REQ-040 The bench SHALL push 12 stores with random i_dc_ready and check that the drain sequence matches push order, confirming correct pointer wrap-around.
